// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// writeback, with a registered write drive and a pending-write scoreboard.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [4:0]        req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [4:0]        req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [4:0]        rsv_addr,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [31:0]       pending,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [31:0]       pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        // On conflict the requester that did not win last time goes first.
        req0_ready = req0_valid && (!req1_valid || last_grant_q);
        req1_ready = req1_valid && !req0_ready;

        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (req0_ready) begin
            last_grant_d = 1'b0;
            wr_en_d      = (req0_addr != 5'd0);
            wr_addr_d    = req0_addr;
            wr_data_d    = req0_data;
        end else if (req1_ready) begin
            last_grant_d = 1'b1;
            wr_en_d      = (req1_addr != 5'd0);
            wr_addr_d    = req1_addr;
            wr_data_d    = req1_data;
        end

        // Clear first so a reservation on the same edge takes precedence.
        pending_d = pending_q;
        if (wr_en_q)
            pending_d[wr_addr_q] = 1'b0;
        if (rsv_valid && rsv_addr != 5'd0)
            pending_d[rsv_addr] = 1'b1;
        pending_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (req0_valid && req1_valid && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            pending_q    <= '0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign pending      = pending_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, multi-cycle corner
// sequences and random traffic against a transaction-level reference model.
module tb_regfile_wr_arbiter;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req1_valid, rsv_valid;
    logic [4:0]        req0_addr, req1_addr, rsv_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [31:0]       pending;
    logic [CNT_W-1:0]  conflict_cnt;

    regfile_wr_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending(pending), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // reference model state
    int          m_last;
    bit          m_wen;
    int          m_wa;
    bit [31:0]   m_wd;
    bit          m_pend[32];
    int          m_cnt;
    int          m_win;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_wen = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        for (int i = 0; i < 32; i++) p[i] = m_pend[i];
        return p;
    endfunction

    // One clock: check ready against the model, advance the model across the
    // edge, then check the registered outputs.
    task automatic cycle();
        bit p_wen; int p_wa; bit both;
        #1;
        both  = req0_valid && req1_valid;
        if (both)            m_win = 1 - m_last;
        else if (req0_valid) m_win = 0;
        else if (req1_valid) m_win = 1;
        else                 m_win = -1;
        chk("req0_ready", req0_ready, m_win == 0);
        chk("req1_ready", req1_ready, m_win == 1);
        p_wen = m_wen; p_wa = m_wa;
        @(posedge clk);
        if (m_win >= 0) begin
            m_last = m_win;
            m_wa   = (m_win == 0) ? req0_addr : req1_addr;
            m_wd   = (m_win == 0) ? req0_data : req1_data;
            m_wen  = (m_wa != 0);
        end else begin
            m_wen  = 0;
        end
        if (p_wen) m_pend[p_wa] = 0;
        if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1;
        if (both && m_cnt < MAXC) m_cnt++;
        #1;
        chk("wr_en", wr_en, m_wen);
        chk("wr_addr", wr_addr, m_wa);
        chk("wr_data", wr_data, m_wd);
        chk("pending", pending, model_pending());
        chk("conflict_cnt", conflict_cnt, m_cnt);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        rsv_valid = 0; rsv_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_pending", pending, 0);
        chk("rst_cnt", conflict_cnt, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1;
    endtask

    typedef struct {
        bit        r0v; bit [4:0] r0a; bit [31:0] r0d;
        bit        r1v; bit [4:0] r1a; bit [31:0] r1d;
        bit        rv;  bit [4:0] ra;
        bit        e0;  bit e1;
        bit        ewen; bit [4:0] ewa; bit [31:0] ewd;
    } vec_t;

    vec_t vt[8];
    int   q0[$], q1[$];
    int   gseq[$];

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        vt[0] = '{1, 1, 32'h11, 1, 11, 32'hBB, 0, 0, 1, 0, 1, 1, 32'h11};
        vt[1] = '{1, 2, 32'h22, 1, 11, 32'hBB, 0, 0, 0, 1, 1, 11, 32'hBB};
        vt[2] = '{1, 2, 32'h22, 0, 0, 0, 0, 0, 1, 0, 1, 2, 32'h22};
        vt[3] = '{1, 0, 32'd12, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'd12};
        vt[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd12};
        vt[5] = '{0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF};
        vt[6] = '{0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 5, 32'hDEADBEEF};
        vt[7] = '{1, 6, 32'h66, 1, 7, 32'h77, 0, 0, 1, 0, 1, 6, 32'h66};
        for (int i = 0; i < 8; i++) begin
            req0_valid = vt[i].r0v; req0_addr = vt[i].r0a; req0_data = vt[i].r0d;
            req1_valid = vt[i].r1v; req1_addr = vt[i].r1a; req1_data = vt[i].r1d;
            rsv_valid  = vt[i].rv;  rsv_addr  = vt[i].ra;
            #1;
            chk($sformatf("vec%0d_rdy0", i), req0_ready, vt[i].e0);
            chk($sformatf("vec%0d_rdy1", i), req1_ready, vt[i].e1);
            cycle();
            chk($sformatf("vec%0d_wen", i), wr_en, vt[i].ewen);
            chk($sformatf("vec%0d_waddr", i), wr_addr, vt[i].ewa);
            chk($sformatf("vec%0d_wdata", i), wr_data, vt[i].ewd);
        end
        idle_inputs();
        chk("pend9_set", pending[9], 1);
        chk("pend0_zero", pending[0], 0);

        // scoreboard: reserve 7, write 7 three cycles later
        rsv_valid = 1; rsv_addr = 7; cycle(); idle_inputs();
        chk("sb_set", pending[7], 1);
        cycle(); cycle();
        req0_valid = 1; req0_addr = 7; req0_data = 32'h7777; cycle(); idle_inputs();
        chk("sb_still_set", pending[7], 1);
        cycle();
        chk("sb_cleared", pending[7], 0);
        // reservation on the clearing edge wins
        req0_valid = 1; req0_addr = 7; req0_data = 32'h7070; cycle(); idle_inputs();
        rsv_valid = 1; rsv_addr = 7; cycle(); idle_inputs();
        chk("sb_set_wins", pending[7], 1);
        rsv_valid = 1; rsv_addr = 0; cycle(); idle_inputs();
        chk("sb_rsv0", pending[0], 0);

        // mid-stream reset with wr_en high, then first conflict goes to req0
        req0_valid = 1; req0_addr = 3; req0_data = 32'h33; cycle();
        chk("pre_rst_wen", wr_en, 1);
        #2;
        do_reset();
        req0_valid = 1; req0_addr = 4; req0_data = 32'h44;
        req1_valid = 1; req1_addr = 8; req1_data = 32'h88;
        #1 chk("post_rst_grant0", req0_ready, 1);
        cycle(); idle_inputs();

        // sustained conflict: four writes each, alternating grants
        do_reset();
        q0 = '{1, 2, 3, 4}; q1 = '{11, 12, 13, 14};
        gseq.delete();
        for (int c = 0; c < 8; c++) begin
            req0_valid = (q0.size() > 0); req0_addr = (q0.size() > 0) ? q0[0] : 0; req0_data = 32'hA0 + c;
            req1_valid = (q1.size() > 0); req1_addr = (q1.size() > 0) ? q1[0] : 0; req1_data = 32'hB0 + c;
            cycle();
            gseq.push_back(m_win);
            if (m_win == 0) void'(q0.pop_front());
            if (m_win == 1) void'(q1.pop_front());
            if (c == 3) chk("conf_cnt4", conflict_cnt, 4);
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) chk($sformatf("conf_grant%0d", c), gseq[c], c % 2);
        chk("conf_done", q0.size() + q1.size(), 0);

        // counter saturation
        do_reset();
        req0_valid = 1; req0_addr = 2; req0_data = 1;
        req1_valid = 1; req1_addr = 3; req1_data = 2;
        repeat (20) cycle();
        chk("cnt_sat", conflict_cnt, MAXC);
        idle_inputs();

        // random traffic, requesters hold until accepted
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && $urandom_range(2) != 0) begin
                req0_valid = 1; req0_addr = $urandom_range(31); req0_data = $urandom;
            end
            if (!req1_valid && $urandom_range(2) != 0) begin
                req1_valid = 1; req1_addr = $urandom_range(31); req1_data = $urandom;
            end
            rsv_valid = ($urandom_range(3) == 0);
            rsv_addr  = $urandom_range(31);
            cycle();
            if (m_win == 0) req0_valid = 0;
            if (m_win == 1) req1_valid = 0;
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single register-file write port (Aw/Dw/WrEn) between two writeback requesters: ALU writeback (requester 0) and load writeback (requester 1). Fair round-robin arbitration with a valid/ready handshake, a registered write-port drive, and a 32-entry pending-write scoreboard for hazard detection. Sits between the execute/memory stages and the RegisterFile write inputs.

## Interface
- DATA_W, 32, write data width
- CNT_W, 16, width of the conflict counter
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a write
- req0_addr  in  5  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 write accepted this cycle (combinational)
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0, for requester 1
- rsv_valid  in  1  reserve a destination at issue
- rsv_addr  in  5  register to mark pending
- wr_en  out  1  to RegisterFile WrEn
- wr_addr  out  5  to RegisterFile Aw
- wr_data  out  DATA_W  to RegisterFile Dw
- pending  out  32  bit i = write to register i outstanding
- conflict_cnt  out  CNT_W  saturating count of cycles with both requesters valid

## Operation
- Handshake: transfer on reqN_valid && reqN_ready. Requester holds addr/data stable while valid and not ready. ready never asserted without valid.
- Arbitration state: last_grant (1 bit). One valid -> that requester granted. Both valid -> grant requester != last_grant. last_grant updates to the granted index on every transfer.
- At most one ready per cycle; no dead cycles: a valid request is always granted unless the other requester wins.
- Issue register: on transfer, wr_addr/wr_data capture the request; wr_en set to 1 unless addr == 0 (write to register 0 accepted, dropped, wr_en 0). No transfer -> wr_en 0; wr_addr/wr_data hold.
- Scoreboard: rsv_valid with rsv_addr != 0 sets pending[rsv_addr]. Clear of pending[wr_addr] on the edge at which wr_en is 1. Set and clear of the same address on the same edge: set wins. pending[0] constantly 0.
- conflict_cnt increments on each cycle with req0_valid && req1_valid; saturates at all ones.

## Timing
- Reset (async, rst_n low): wr_en 0, wr_addr 0, wr_data 0, pending 0, conflict_cnt 0, last_grant 1 (requester 0 wins first conflict). reqN_ready is combinational and follows valid regardless of reset state; upstream keeps valid low in reset. Reset asserted mid-operation drops any registered write (wr_en 0 immediately).
- Latency: transfer in cycle T -> wr_en/wr_addr/wr_data driven during T+1 -> RegisterFile captures on the edge ending T+1 -> readable on Da/Db and pending bit low from T+2.
- Throughput: one write per cycle; back-to-back transfers give wr_en high on consecutive cycles.
- Continuous conflict alternates grants 0,1,0,1...; each requester waits at most one cycle.
- Reservation in cycle T: pending bit high from T+1.

## Test plan
- Reset: drive rst_n low mid-stream with wr_en high -> wr_en, pending, conflict_cnt read 0 immediately; first conflict after release grants req0.
- Single requester: req1 writes addr 5, data 0xDEADBEEF in T -> req1_ready=1 in T, wr_en=1/wr_addr=5/wr_data=0xDEADBEEF in T+1, Da at Aa=5 reads 0xDEADBEEF in T+2.
- Conflict: both valid for 4 cycles (req0 addrs 1-4, req1 addrs 11-14) -> grants 0,1,0,1; each requester completes its 4 writes within 8 cycles; conflict_cnt reads 4 after the first 4 cycles.
- Register 0: req0 writes addr 0, data 12 -> req0_ready=1, wr_en stays 0, Da at Aa=0 reads 0; rsv to addr 0 -> pending stays 0.
- Scoreboard: rsv addr 7 in T -> pending[7]=1 at T+1; write to 7 transfers in T+3 -> pending[7]=0 at T+5; rsv 7 on the same edge as the clearing write -> pending[7] stays 1.
- Saturation: force CNT_W=4, hold both valid 20 cycles -> conflict_cnt stops at 15.
